// File: rtl/picorv32_wbuf.sv
// picorv32_wbuf -- posted-write buffer between the PicoRV32 native memory
// interface and picorv32_freeahb_adapter.
//
// Writes are acknowledged to the core one cycle after they are sampled and
// queued in a small FIFO. The FIFO drains in order to the adapter, one
// request at a time with an idle cycle between requests. Reads and
// instruction fetches are issued downstream only once the buffer is empty,
// so they are ordered behind every queued write.
//
// Optional feature, macro PICORV_WBUF_FWD_EN: a data read whose youngest
// matching FIFO entry (same addr[31:2]) carries a full 4'b1111 strobe is
// answered directly from the FIFO with no downstream access.
//
// Parameters:
//   DEPTH       FIFO entries, power of two, 2..16
//   CW          width of wbuf_count, log2(DEPTH)+1
// Ports:
//   clk, resetn                       clock, synchronous active-low reset
//   mem_valid/instr/addr/wdata/wstrb  core request (wstrb==0 means read)
//   mem_ready, mem_rdata              core completion pulse, registered data
//   dn_valid/instr/addr/wdata/wstrb   request to the adapter
//   dn_ready, dn_rdata                adapter completion and read data
//   wbuf_empty                        nothing queued and no drain in flight
//   wbuf_count                        number of FIFO entries held
module picorv32_wbuf #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          mem_valid,
    input  logic          mem_instr,
    output logic          mem_ready,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic [31:0]   mem_rdata,
    output logic          dn_valid,
    output logic          dn_instr,
    input  logic          dn_ready,
    output logic [31:0]   dn_addr,
    output logic [31:0]   dn_wdata,
    output logic [3:0]    dn_wstrb,
    input  logic [31:0]   dn_rdata,
    output logic          wbuf_empty,
    output logic [CW-1:0] wbuf_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_RD    = 2'd2
    } state_t;

    entry_t        fifo [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    state_t state;
    state_t state_nxt;

    logic        sample;
    logic        is_wr;
    logic        full;
    logic        push;
    logic        rd_req;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    logic ld_drain;
    logic ld_rd;
    logic pop;
    logic rd_done;

    // The core holds mem_valid until it sees mem_ready and drops it on the
    // following edge, so the mem_ready cycle itself is never sampled.
    assign sample = mem_valid && !mem_ready;
    assign is_wr  = |mem_wstrb;
    assign full   = (count == CW'(DEPTH));
    // A full FIFO refuses the push even if a pop happens on the same edge.
    assign push   = sample && is_wr && !full;

`ifdef PICORV_WBUF_FWD_EN
    logic [AW-1:0] fwd_idx;
    logic          fwd_match;
    logic          fwd_full;

    // Walk from oldest to youngest so the last hit is the youngest entry.
    always_comb begin
        fwd_idx   = rd_ptr;
        fwd_match = 1'b0;
        fwd_full  = 1'b0;
        fwd_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + AW'(i);
            if ((CW'(i) < count) && (fifo[fwd_idx].addr[31:2] == mem_addr[31:2])) begin
                fwd_match = 1'b1;
                fwd_full  = (fifo[fwd_idx].wstrb == 4'hF);
                fwd_data  = fifo[fwd_idx].wdata;
            end
        end
        fwd_hit = sample && !is_wr && !mem_instr && fwd_match && fwd_full;
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    assign rd_req = sample && !is_wr && !fwd_hit;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // FSM: next state. Draining has priority over a pending read, and a
    // read only starts once the FIFO is empty.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (count != '0) state_nxt = S_DRAIN;
                else if (rd_req) state_nxt = S_RD;
            end
            S_DRAIN: if (dn_ready) state_nxt = S_IDLE;
            S_RD:    if (dn_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs (datapath strobes)
    always_comb begin
        ld_drain = 1'b0;
        ld_rd    = 1'b0;
        pop      = 1'b0;
        rd_done  = 1'b0;
        case (state)
            S_IDLE: begin
                ld_drain = (count != '0);
                ld_rd    = (count == '0) && rd_req;
            end
            S_DRAIN: pop     = dn_ready;
            S_RD:    rd_done = dn_ready;
            default: ;
        endcase
    end

    // Entry storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= '{addr: mem_addr, wdata: mem_wdata,
                                    wstrb: mem_wstrb, instr: mem_instr};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            dn_valid  <= 1'b0;
            dn_instr  <= 1'b0;
            dn_addr   <= '0;
            dn_wdata  <= '0;
            dn_wstrb  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);

            mem_ready <= push || rd_done || fwd_hit;
            if (rd_done)      mem_rdata <= dn_rdata;
            else if (fwd_hit) mem_rdata <= fwd_data;

            // dn_* hold steady from load until the dn_ready edge.
            if (ld_drain) begin
                dn_valid <= 1'b1;
                dn_addr  <= fifo[rd_ptr].addr;
                dn_wdata <= fifo[rd_ptr].wdata;
                dn_wstrb <= fifo[rd_ptr].wstrb;
                dn_instr <= fifo[rd_ptr].instr;
            end else if (ld_rd) begin
                dn_valid <= 1'b1;
                dn_addr  <= mem_addr;
                dn_wstrb <= 4'h0;
                dn_instr <= mem_instr;
            end else if (pop || rd_done) begin
                dn_valid <= 1'b0;
            end
        end
    end

    assign wbuf_empty = (count == '0) && (state != S_DRAIN);
    assign wbuf_count = count;

endmodule

// File: tb/tb_picorv32_wbuf.sv
// Scoreboard bench for picorv32_wbuf: the core driver pushes expected
// upstream responses and expected downstream requests into queues as it
// issues; independent monitors pop and compare whenever the DUT presents
// mem_ready or a new dn_valid request. A small adapter model with its own
// memory answers downstream requests.
module tb_picorv32_wbuf;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          mem_valid = 1'b0;
    logic          mem_instr = 1'b0;
    logic          mem_ready;
    logic [31:0]   mem_addr = '0;
    logic [31:0]   mem_wdata = '0;
    logic [3:0]    mem_wstrb = '0;
    logic [31:0]   mem_rdata;
    logic          dn_valid;
    logic          dn_instr;
    logic          dn_ready = 1'b0;
    logic [31:0]   dn_addr;
    logic [31:0]   dn_wdata;
    logic [3:0]    dn_wstrb;
    logic [31:0]   dn_rdata = '0;
    logic          wbuf_empty;
    logic [CW-1:0] wbuf_count;

    always #5 clk = ~clk;

    picorv32_wbuf #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .dn_valid(dn_valid), .dn_instr(dn_instr), .dn_ready(dn_ready),
        .dn_addr(dn_addr), .dn_wdata(dn_wdata), .dn_wstrb(dn_wstrb),
        .dn_rdata(dn_rdata),
        .wbuf_empty(wbuf_empty), .wbuf_count(wbuf_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } dreq_t;

    dreq_t       exp_dn[$];
    logic [31:0] exp_up[$];
    logic [31:0] ref_mem [bit [29:0]];
    logic [31:0] adp_mem [bit [29:0]];
    logic [31:0] last_rd = '0;

    int n_pass = 0;
    int n_tot  = 0;
    bit stall = 1'b0;
    int lat_fix = -1;

    function automatic logic [31:0] init_word(bit [29:0] w);
        return {w[15:0] ^ 16'h5A5A, w[15:0]};
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] s);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h want %08h", nm, act, exp);
    endtask

    task automatic fail(input string nm, input string what);
        n_tot++;
        $display("FAIL %s: %s", nm, what);
    endtask

    // Core request: record expectations, drive, wait (bounded) for mem_ready.
    task automatic core_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic ins, input bit fwd, input bit chk_lat);
        dreq_t       r;
        int          w;
        bit          got;
        bit [29:0]   wa;
        logic [31:0] cur;
        wa  = a[31:2];
        cur = ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
        if (s != 4'h0) begin
            ref_mem[wa] = merge(cur, d, s);
            exp_up.push_back(last_rd);
            r = '{a, d, s, ins};
            exp_dn.push_back(r);
        end else begin
            exp_up.push_back(cur);
            last_rd = cur;
            if (!fwd) begin
                r = '{a, 32'h0, 4'h0, ins};
                exp_dn.push_back(r);
            end
        end
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins;
        w = 0; got = 1'b0;
        while (!got && w < 400) begin
            @(negedge clk);
            w++;
            if (mem_ready) got = 1'b1;
        end
        mem_valid = 1'b0; mem_wstrb = 4'h0; mem_instr = 1'b0;
        if (!got) fail("core_timeout", "got no mem_ready want ack within 400 cycles");
        else if (chk_lat) chk("ack_latency", w, 1);
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((exp_dn.size() != 0 || !wbuf_empty || dn_valid) && w < 600) begin
            @(negedge clk);
            w++;
        end
        if (w >= 600) fail("drain_timeout", "got buffer busy want empty within 600 cycles");
    endtask

    // Upstream monitor
    bit prev_rdy = 1'b0;
    always @(negedge clk) begin
        if (!resetn) prev_rdy = 1'b0;
        else begin
            if (mem_ready) begin
                if (prev_rdy) fail("ready_pulse", "got mem_ready two cycles want one");
                if (exp_up.size() == 0) fail("ready_unexpected", "got mem_ready want none");
                else chk("mem_rdata", mem_rdata, exp_up.pop_front());
            end
            chk("empty_vs_count", wbuf_empty, (wbuf_count == 0));
            prev_rdy = mem_ready;
        end
    end

    // Downstream monitor: order/content of each new request and stability.
    bit          dprev = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_wstrb;
    logic        h_instr;
    always @(negedge clk) begin
        dreq_t e;
        if (!resetn) dprev = 1'b0;
        else begin
            if (dn_valid && !dprev) begin
                if (exp_dn.size() == 0) fail("dn_unexpected", "got dn_valid want no request");
                else begin
                    e = exp_dn.pop_front();
                    chk("dn_addr", dn_addr, e.addr);
                    chk("dn_wstrb", dn_wstrb, e.wstrb);
                    chk("dn_instr", dn_instr, e.instr);
                    if (e.wstrb != 4'h0) chk("dn_wdata", dn_wdata, e.wdata);
                    else chk("rd_after_drain", wbuf_empty, 1);
                end
                h_addr = dn_addr; h_wdata = dn_wdata; h_wstrb = dn_wstrb; h_instr = dn_instr;
            end else if (dn_valid) begin
                chk("dn_hold", (dn_addr == h_addr && dn_wdata == h_wdata &&
                                dn_wstrb == h_wstrb && dn_instr == h_instr), 1);
            end
            dprev = dn_valid;
        end
    end

    // Adapter model
    int lat = 0;
    int tgt = 0;
    always begin
        bit [29:0]   wa;
        logic [31:0] cur;
        @(negedge clk);
        if (dn_ready) begin
            dn_ready = 1'b0;
            chk("dn_valid_drop", dn_valid, 0);
            lat = 0;
            tgt = $urandom_range(0, 4);
        end else if (resetn && dn_valid) begin
            if (!stall && lat >= ((lat_fix >= 0) ? lat_fix : tgt)) begin
                wa  = dn_addr[31:2];
                cur = adp_mem.exists(wa) ? adp_mem[wa] : init_word(wa);
                if (dn_wstrb != 4'h0) begin
                    adp_mem[wa] = merge(cur, dn_wdata, dn_wstrb);
                    dn_rdata = $urandom;
                end else dn_rdata = cur;
                dn_ready = 1'b1;
            end else lat++;
        end else lat = 0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_mem_ready"}, mem_ready, 0);
        chk({tag, "_mem_rdata"}, mem_rdata, 0);
        chk({tag, "_dn_valid"}, dn_valid, 0);
        chk({tag, "_dn_instr"}, dn_instr, 0);
        chk({tag, "_dn_addr"}, dn_addr, 0);
        chk({tag, "_dn_wdata"}, dn_wdata, 0);
        chk({tag, "_dn_wstrb"}, dn_wstrb, 0);
        chk({tag, "_wbuf_empty"}, wbuf_empty, 1);
        chk({tag, "_wbuf_count"}, wbuf_count, 0);
    endtask

    bit seen;
    bit got;
    logic [3:0]  rs;
    logic [31:0] ra;
    int op;

    initial begin
        ref_mem[30'h300 >> 2] = 32'h12345678;
        adp_mem[30'h300 >> 2] = 32'h12345678;

        repeat (3) @(negedge clk);
        reset_checks("por");
        resetn = 1'b1;

        // Posted writes with a fixed 5-cycle adapter latency
        lat_fix = 5;
        for (int i = 0; i < 4; i++)
            core_req(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 1'b0, 1'b0, 1'b1);
        wait_idle();
        lat_fix = -1;

        // Read ordered behind a write
        core_req(32'h200, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b1);
        core_req(32'h300, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        wait_idle();
        chk("rd_value", mem_rdata, 32'h12345678);

        // Full stall and release
        stall = 1'b1;
        for (int i = 0; i < 4; i++)
            core_req(32'h500 + 32'(4 * i), 32'h50 + 32'(i), 4'hF, 1'b0, 1'b0, 1'b1);
        fork
            core_req(32'h510, 32'h55, 4'hF, 1'b0, 1'b0, 1'b0);
            begin
                seen = 1'b0;
                repeat (4) begin @(negedge clk); if (mem_ready) seen = 1'b1; end
                chk("full_no_ack", seen, 0);
                chk("full_count", wbuf_count, 4);
                stall = 1'b0;
                got = 1'b0;
                for (int k = 0; k < 50 && !got; k++) begin
                    @(posedge clk);
                    if (dn_ready) got = 1'b1;
                end
                if (!got) fail("pop_timeout", "got no dn_ready want pop");
                else begin
                    @(negedge clk);
                    chk("pop_edge_ack", mem_ready, 0);
                    chk("pop_edge_count", wbuf_count, 3);
                    @(negedge clk);
                    chk("post_pop_ack", mem_ready, 1);
                    chk("post_pop_count", wbuf_count, 4);
                end
            end
        join
        wait_idle();

        // Reset with three writes queued
        stall = 1'b1;
        for (int i = 0; i < 3; i++)
            core_req(32'h900 + 32'(4 * i), 32'h90 + 32'(i), 4'hF, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        reset_checks("mid");
        @(negedge clk);
        resetn = 1'b1;
        stall = 1'b0;
        exp_dn.delete();
        for (int i = 0; i < 3; i++) ref_mem.delete(30'((32'h900 + 32'(4 * i)) >> 2));
        last_rd = '0;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); if (dn_valid) seen = 1'b1; end
        chk("no_dn_after_reset", seen, 0);
        chk("after_reset_count", wbuf_count, 0);

`ifdef PICORV_WBUF_FWD_EN
        // Forwarding: full-strobe hit answered locally, partial hit waits
        stall = 1'b1;
        core_req(32'h400, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 1'b1);
        core_req(32'h400, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        chk("fwd_value", mem_rdata, 32'hCAFEF00D);
        core_req(32'h404, 32'h11, 4'b0001, 1'b0, 1'b0, 1'b1);
        fork
            core_req(32'h404, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
            begin
                seen = 1'b0;
                repeat (5) begin @(negedge clk); if (mem_ready) seen = 1'b1; end
                chk("partial_no_fwd", seen, 0);
                stall = 1'b0;
            end
        join
        wait_idle();
`endif

        // Fetch behind two queued writes
        stall = 1'b1;
        core_req(32'h600, 32'h66, 4'hF, 1'b0, 1'b0, 1'b1);
        core_req(32'h604, 32'h67, 4'hF, 1'b0, 1'b0, 1'b1);
        fork
            core_req(32'h600, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
            begin
                seen = 1'b0;
                repeat (4) begin @(negedge clk); if (mem_ready) seen = 1'b1; end
                chk("fetch_waits", seen, 0);
                stall = 1'b0;
            end
        join
        wait_idle();
        chk("fetch_value", mem_rdata, 32'h00000066);

        // Random traffic over a small address window
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 9);
            ra = 32'h1000 + 32'(4 * $urandom_range(0, 7));
`ifdef PICORV_WBUF_FWD_EN
            rs = 4'($urandom_range(1, 14));
`else
            rs = 4'($urandom_range(1, 15));
`endif
            if (op < 5)      core_req(ra, $urandom, rs, 1'b0, 1'b0, 1'b0);
            else if (op < 8) core_req(ra, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
            else             core_req(ra, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("exp_up_drained", exp_up.size(), 0);
        chk("exp_dn_drained", exp_dn.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
